// File: rtl/asteroid_scheduler.sv
// rtl/asteroid_scheduler.sv - asteroid game scheduler: slot spawning, hits, impacts, lives/score FSM
module asteroid_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int SPAWN_PERIOD = 50,
  parameter int START_LIVES  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 fire,
  input  logic                 hit_valid,
  input  logic [2:0]           hit_slot,
  input  logic                 impact_valid,
  input  logic [2:0]           impact_slot,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic                 spawn_pulse,
  output logic [2:0]           spawn_slot,
  output logic [3:0]           lives,
  output logic [7:0]           score,
  output logic [1:0]           game_state
);

  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} gameStateT;

  localparam logic [7:0] LAST_TICK = 8'(SPAWN_PERIOD - 1);

  gameStateT state, stateNext;
  logic [NUM_SLOTS-1:0] slotNext, hitMask, impactMask, freeMask;
  logic [2:0] spawnSlotNext;
  logic [3:0] livesNext;
  logic [7:0] scoreNext, spawnTimer, timerNext;
  logic pending, pendingNext, pulseNext, fireQ, fireArmed, fireEdge, spawnDue, freeFound;

  // fireArmed blocks a press that was already held through reset from counting as an edge
  assign fireEdge   = fire & ~fireQ & fireArmed;
  assign spawnDue   = frame_tick && (spawnTimer == LAST_TICK);
  assign game_state = state;

  // Descending scan so the lowest free index is the one left in freeMask
  always_comb begin
    hitMask    = '0;
    impactMask = '0;
    freeMask   = '0;
    freeFound  = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit_valid && hit_slot == 3'(i) && slot_active[i]) hitMask[i] = 1'b1;
      if (impact_valid && impact_slot == 3'(i) && slot_active[i]) impactMask[i] = 1'b1;
      if (!slot_active[i]) begin
        freeMask    = '0;
        freeMask[i] = 1'b1;
        freeFound   = 1'b1;
      end
    end
    impactMask = impactMask & ~hitMask;
  end

  always_comb begin
    stateNext     = state;
    slotNext      = slot_active;
    pulseNext     = 1'b0;
    spawnSlotNext = spawn_slot;
    livesNext     = lives;
    scoreNext     = score;
    timerNext     = spawnTimer;
    pendingNext   = pending;
    case (state)
      IDLE: begin
        slotNext = '0;
        if (fireEdge) begin
          stateNext   = PLAY;
          livesNext   = 4'(START_LIVES);
          scoreNext   = 8'd0;
          timerNext   = 8'd0;
          pendingNext = 1'b0;
        end
      end
      PLAY: begin
        slotNext = slot_active & ~hitMask & ~impactMask;
        if (|hitMask && score != 8'hFF) scoreNext = score + 8'd1;
        if (|impactMask) livesNext = lives - 4'd1;
        if (|impactMask && lives == 4'd1) begin
          stateNext   = OVER;
          slotNext    = '0;
          pendingNext = 1'b0;
          timerNext   = 8'd0;
        end else begin
          if (pending) timerNext = 8'd0;
          else if (frame_tick) timerNext = spawnDue ? 8'd0 : spawnTimer + 8'd1;
          // Selection uses pre-clear occupancy; a slot freed now is offered next cycle
          if (pending || spawnDue) begin
            if (freeFound) begin
              slotNext    = slotNext | freeMask;
              pulseNext   = 1'b1;
              pendingNext = 1'b0;
              for (int i = 0; i < NUM_SLOTS; i++)
                if (freeMask[i]) spawnSlotNext = 3'(i);
            end else begin
              pendingNext = 1'b1;
            end
          end
        end
      end
      OVER: begin
        slotNext = '0;
        if (fireEdge) stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        slotNext  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slot_active <= '0;
      spawn_pulse <= 1'b0;
      spawn_slot  <= 3'd0;
      lives       <= 4'd0;
      score       <= 8'd0;
      spawnTimer  <= 8'd0;
      pending     <= 1'b0;
      fireQ       <= 1'b0;
      fireArmed   <= 1'b0;
    end else begin
      state       <= stateNext;
      slot_active <= slotNext;
      spawn_pulse <= pulseNext;
      spawn_slot  <= spawnSlotNext;
      lives       <= livesNext;
      score       <= scoreNext;
      spawnTimer  <= timerNext;
      pending     <= pendingNext;
      fireQ       <= fire;
      fireArmed   <= fireArmed | ~fire;
    end
  end

endmodule

// File: doc/asteroid_scheduler.md
ASTEROID_SCHEDULER -- requirements
Module: asteroid_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: number of asteroid slots (range 2..8).
REQ-002 SHALL have parameter SPAWN_PERIOD, default 50: frames between spawn attempts (range 2..255).
REQ-003 SHALL have parameter START_LIVES, default 3: lives loaded at game start (range 1..15).
REQ-004 SHALL have port clk  input  1: single system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port frame_tick  input  1: one-cycle pulse per video frame.
REQ-007 SHALL have port fire  input  1: player button, level, synchronous to clk.
REQ-008 SHALL have port hit_valid  input  1: one-cycle pulse, asteroid destroyed by defense.
REQ-009 SHALL have port hit_slot  input  3: slot index for hit_valid.
REQ-010 SHALL have port impact_valid  input  1: one-cycle pulse, asteroid reached planet.
REQ-011 SHALL have port impact_slot  input  3: slot index for impact_valid.
REQ-012 SHALL have port slot_active  output  NUM_SLOTS: bit i high while slot i holds a live asteroid.
REQ-013 SHALL have port spawn_pulse  output  1: one-cycle pulse when a slot is loaded.
REQ-014 SHALL have port spawn_slot  output  3: index of slot loaded; valid with spawn_pulse.
REQ-015 SHALL have port lives  output  4: remaining lives.
REQ-016 SHALL have port score  output  8: destroyed-asteroid count.
REQ-017 SHALL have port game_state  output  2: 00 IDLE, 01 PLAY, 10 OVER.

Function
REQ-018 SHALL implement FSM IDLE, PLAY, OVER; encoding 2'b11 unused, recovers to IDLE next cycle.
REQ-019 SHALL detect fire rising edge with a registered previous-value flop; edge = fire & ~fire_q.
REQ-020 IDLE: on fire edge SHALL enter PLAY next cycle, load lives=START_LIVES, score=0, slot_active=0, spawn timer=0.
REQ-021 PLAY: spawn timer SHALL increment on each frame_tick; at frame_tick with timer==SPAWN_PERIOD-1 a spawn is due and timer returns to 0.
REQ-022 Due spawn SHALL load the lowest-index slot with slot_active=0; spawn_pulse and spawn_slot asserted that same registered cycle as slot_active bit sets (1-cycle latency from frame_tick).
REQ-023 If no slot free when due, spawn SHALL be pending; timer holds at 0; spawn issues on first cycle a slot is free, without waiting for frame_tick; at most one pending spawn.
REQ-024 hit_valid on an active slot SHALL clear that slot next cycle and increment score, saturating at 255.
REQ-025 impact_valid on an active slot SHALL clear that slot next cycle and decrement lives.
REQ-026 hit_valid/impact_valid on inactive slot or slot index >= NUM_SLOTS SHALL be ignored.
REQ-027 hit and impact on same slot same cycle: hit wins; score increments, lives unchanged.
REQ-028 hit and impact on different slots same cycle: both applied.
REQ-029 Spawn selection SHALL use slot_active before clears of the same cycle; a slot freed this cycle is available next cycle.
REQ-030 When an applied impact takes lives from 1 to 0, SHALL enter OVER next cycle, clear slot_active, cancel pending spawn; no spawn_pulse that cycle.
REQ-031 OVER: score and lives SHALL hold; frame_tick, hit, impact ignored; fire edge returns to IDLE.
REQ-032 IDLE and OVER SHALL keep slot_active=0 and spawn_pulse=0.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst high SHALL immediately force game_state=IDLE, slot_active=0, spawn_pulse=0, spawn_slot=0, lives=0, score=0, timer=0, pending=0, fire_q=0.
REQ-035 rst asserted mid-PLAY SHALL discard pending spawn and all counters; after release, fire held high produces no edge until released and re-pressed.

Verification
REQ-036 Reset, fire edge -> game_state=01 next cycle, lives=3, score=0, slot_active=0000.
REQ-037 PLAY, 50 frame_ticks -> spawn_pulse once, spawn_slot=0, slot_active=0001; 200 ticks -> slot_active=1111, slots 0..3 in order.
REQ-038 All 4 active, 50 more ticks -> no pulse; hit_valid slot 2 -> score=1, slot_active=1011, next cycle spawn_pulse with spawn_slot=2.
REQ-039 Same cycle hit_valid and impact_valid both slot 1 -> score+1, lives unchanged, slot 1 cleared.
REQ-040 Three impacts on active slots -> lives 3,2,1,0, game_state=10, slot_active=0000; later frame_ticks produce no spawn; fire edge -> IDLE.
REQ-041 score=255, hit on active slot -> score stays 255; rst mid-PLAY -> all outputs zero, game_state=00 asynchronously.
